// File: rtl/rv32_pkg.sv
// ----------------------------------------------------------------------------
// rv32_pkg
// Shared definitions for the rv32 memory arbiter: word width, owner encodings
// and the read-tag payload that travels alongside each RAM access.
// ----------------------------------------------------------------------------
package rv32_pkg;

    // Architectural word width of the core and the unified RAM.
    localparam int unsigned XLEN = 32;

    // Owner of a RAM read, carried in the tag so the data can be returned.
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

    // Per-access tag: valid marks a read that expects data back.
    typedef struct packed {
        logic valid;
        logic owner;
    } tag_t;

endpackage : rv32_pkg

// File: rtl/rv32_arb_tag_pipe.sv
// ----------------------------------------------------------------------------
// rv32_arb_tag_pipe
// DEPTH-stage shift register of read tags. The tail stage lines up with the
// RAM read data, DEPTH cycles after the access that entered the tag.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low clear of every stage
//   tag_in   in   tag for the access granted this cycle
//   tag_out  out  tag of the access whose read data is on the RAM bus now
// ----------------------------------------------------------------------------
module rv32_arb_tag_pipe
    import rv32_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t tag_out
);

    if (DEPTH == 1) begin : g_single
        tag_t stage_q;

        // Single stage: the tag simply waits one cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_q <= '0;
            end else begin
                stage_q <= tag_in;
            end
        end

        assign tag_out = stage_q;
    end else begin : g_multi
        tag_t [DEPTH-1:0] stage_q;

        // Shift toward the tail; index 0 is the newest entry.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_q <= '0;
            end else begin
                stage_q <= {stage_q[DEPTH-2:0], tag_in};
            end
        end

        assign tag_out = stage_q[DEPTH-1];
    end

endmodule : rv32_arb_tag_pipe

// File: rtl/rv32_mem_arbiter.sv
// ----------------------------------------------------------------------------
// rv32_mem_arbiter
// Shares one single-port synchronous RAM between the instruction-fetch port
// and the load/store port of an rv32 core. One access is granted per cycle;
// data wins, except that after MAX_D_RUN consecutive data grants with fetch
// waiting, fetch is granted. Reads are tagged and their data is routed back
// to the owning port MEM_LAT cycles after the grant.
//
// Optional feature: define RV32_ARB_STATS_EN to add the stat_* counters.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   if_req/if_addr        fetch request, held until if_gnt
//   if_gnt                fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata    fetch read return
//   d_req/d_we/d_be/
//   d_addr/d_wdata        data request, held until d_gnt
//   d_gnt                 data accepted this cycle (combinational)
//   d_rvalid/d_rdata      load read return
//   mem_en/mem_we/mem_be/
//   mem_addr/mem_wdata    RAM command for the granted port (combinational)
//   mem_rdata             RAM read data, MEM_LAT cycles after a read
//   stat_if_gnt           [stats] fetch grant count
//   stat_d_gnt            [stats] data grant count
//   stat_if_stall         [stats] cycles with fetch waiting
// ----------------------------------------------------------------------------
module rv32_mem_arbiter
    import rv32_pkg::*;
#(
    parameter int unsigned AW        = 10,
    parameter int unsigned MEM_LAT   = 1,
    parameter int unsigned MAX_D_RUN = 4
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,

    input  logic            d_req,
    input  logic            d_we,
    input  logic [3:0]      d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [XLEN-1:0] d_rdata,

    output logic            mem_en,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
`ifdef RV32_ARB_STATS_EN
    ,
    output logic [XLEN-1:0] stat_if_gnt,
    output logic [XLEN-1:0] stat_d_gnt,
    output logic [XLEN-1:0] stat_if_stall
`endif
);

    localparam int unsigned     RUN_W   = 4;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_D_RUN);

    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_d;
    logic             d_win;
    tag_t             tag_in;
    tag_t             tag_out;
    logic [XLEN-1:0]  if_rdata_q;
    logic [XLEN-1:0]  d_rdata_q;

    // Grant: data first unless fetch has waited through a full data run.
    // Grants are forced low while reset is asserted so every output is quiet.
    always_comb begin
        d_win  = d_req & (~if_req | (run_q < RUN_MAX));
        d_gnt  = rst_n & d_win;
        if_gnt = rst_n & if_req & ~d_win;
    end

    // RAM command mux from the granted port; idle drives all zeros.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (d_gnt) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_be    = d_be;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (if_gnt) begin
            mem_en    = 1'b1;
            mem_be    = 4'hF;
            mem_addr  = if_addr;
        end
    end

    // Run counter: consecutive data grants while fetch is waiting.
    always_comb begin
        run_d = run_q;
        if (!if_req || if_gnt) begin
            run_d = '0;
        end else if (d_gnt && (run_q < RUN_MAX)) begin
            run_d = run_q + RUN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

    // Tag entering the pipe: only reads expect data back.
    always_comb begin
        tag_in.valid = (d_gnt & ~d_we) | if_gnt;
        tag_in.owner = d_gnt ? OWN_D : OWN_IF;
    end

    rv32_arb_tag_pipe #(
        .DEPTH (MEM_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign if_rvalid = tag_out.valid & (tag_out.owner == OWN_IF);
    assign d_rvalid  = tag_out.valid & (tag_out.owner == OWN_D);

    // Each port's rdata shows RAM data on its return cycle, else its last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (if_rvalid) begin
                if_rdata_q <= mem_rdata;
            end
            if (d_rvalid) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

    assign if_rdata = if_rvalid ? mem_rdata : if_rdata_q;
    assign d_rdata  = d_rvalid  ? mem_rdata : d_rdata_q;

`ifdef RV32_ARB_STATS_EN
    // Free-running event counters, wrapping modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_if_gnt   <= '0;
            stat_d_gnt    <= '0;
            stat_if_stall <= '0;
        end else begin
            stat_if_gnt   <= stat_if_gnt + XLEN'(if_gnt);
            stat_d_gnt    <= stat_d_gnt + XLEN'(d_gnt);
            stat_if_stall <= stat_if_stall + XLEN'(if_req & ~if_gnt);
        end
    end
`endif

endmodule : rv32_mem_arbiter

// File: tb/tb_rv32_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rv32_mem_arbiter
// Directed bench for rv32_mem_arbiter with MEM_LAT = 2 and MAX_D_RUN = 4.
// A table of per-cycle vectors drives the request ports and lists the
// hand-computed grants, RAM command and read returns; a behavioural RAM
// (write-first, MEM_LAT read latency) answers the arbiter.
// ----------------------------------------------------------------------------
module tb_rv32_mem_arbiter;
    import rv32_pkg::*;

    localparam int unsigned AW        = 10;
    localparam int unsigned MEM_LAT   = 2;
    localparam int unsigned MAX_D_RUN = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            if_req = 1'b0;
    logic [AW-1:0]   if_addr = '0;
    logic            if_gnt;
    logic            if_rvalid;
    logic [31:0]     if_rdata;
    logic            d_req = 1'b0;
    logic            d_we = 1'b0;
    logic [3:0]      d_be = 4'h0;
    logic [AW-1:0]   d_addr = '0;
    logic [31:0]     d_wdata = '0;
    logic            d_gnt;
    logic            d_rvalid;
    logic [31:0]     d_rdata;
    logic            mem_en;
    logic            mem_we;
    logic [3:0]      mem_be;
    logic [AW-1:0]   mem_addr;
    logic [31:0]     mem_wdata;
    logic [31:0]     mem_rdata;
`ifdef RV32_ARB_STATS_EN
    logic [31:0]     stat_if_gnt;
    logic [31:0]     stat_d_gnt;
    logic [31:0]     stat_if_stall;
`endif

    int checks = 0;
    int errors = 0;
    int cur_row = -1;

    always #5 clk = ~clk;

    rv32_mem_arbiter #(
        .AW        (AW),
        .MEM_LAT   (MEM_LAT),
        .MAX_D_RUN (MAX_D_RUN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_be      (d_be),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef RV32_ARB_STATS_EN
        ,
        .stat_if_gnt   (stat_if_gnt),
        .stat_d_gnt    (stat_d_gnt),
        .stat_if_stall (stat_if_stall)
`endif
    );

    // ---------------- behavioural RAM ----------------
    logic [31:0] wr_mem [int unsigned];
    logic [31:0] rd_pipe [MEM_LAT];

    function automatic logic [31:0] base_val(input logic [AW-1:0] a);
        if (a == AW'(16)) return 32'hDEADBEEF;
        if (a == AW'(32)) return 32'hFFFFFFFF;
        if (a < AW'(16))  return 32'hA000_0000 | 32'(a);
        return 32'h0;
    endfunction

    function automatic logic [31:0] rd_word(input logic [AW-1:0] a);
        if (wr_mem.exists(32'(a))) return wr_mem[32'(a)];
        return base_val(a);
    endfunction

    always @(posedge clk) begin
        logic [31:0] cur;
        if (mem_en && mem_we) begin
            cur = rd_word(mem_addr);
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
            end
            wr_mem[32'(mem_addr)] = cur;
        end
        rd_pipe[0] <= (mem_en && !mem_we) ? rd_word(mem_addr) : 32'h0;
        for (int i = 1; i < int'(MEM_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign mem_rdata = rd_pipe[MEM_LAT-1];

    // ---------------- vectors ----------------
    typedef struct {
        logic          ir;
        logic [AW-1:0] ia;
        logic          dr;
        logic          dwe;
        logic [3:0]    dbe;
        logic [AW-1:0] da;
        logic [31:0]   dwd;
        logic          ig;
        logic          dg;
        logic          men;
        logic          mwe;
        logic [3:0]    mbe;
        logic [AW-1:0] maddr;
        logic [31:0]   mwd;
        logic          irv;
        logic [31:0]   ird;
        logic          drv;
        logic [31:0]   drd;
    } vec_t;

    vec_t vecs [$];

    function automatic logic [31:0] a_word(input int k);
        return 32'hA000_0000 + 32'(k);
    endfunction

    // Fetch granted; optional competing load from 0x10 loses.
    function automatic vec_t fetch_v(input int ia, input logic dr,
                                     input logic irv, input logic [31:0] ird,
                                     input logic drv, input logic [31:0] drd);
        vec_t v;
        v = '{ir: 1'b1, ia: AW'(ia), dr: dr, dwe: 1'b0, dbe: 4'hF, da: AW'(16),
              dwd: 32'h0, ig: 1'b1, dg: 1'b0, men: 1'b1, mwe: 1'b0, mbe: 4'hF,
              maddr: AW'(ia), mwd: 32'h0, irv: irv, ird: ird, drv: drv, drd: drd};
        return v;
    endfunction

    // Data granted; optional competing fetch loses.
    function automatic vec_t data_v(input logic ir, input int ia, input logic we,
                                    input logic [3:0] be, input int da,
                                    input logic [31:0] wd,
                                    input logic irv, input logic [31:0] ird,
                                    input logic drv, input logic [31:0] drd);
        vec_t v;
        v = '{ir: ir, ia: AW'(ia), dr: 1'b1, dwe: we, dbe: be, da: AW'(da),
              dwd: wd, ig: 1'b0, dg: 1'b1, men: 1'b1, mwe: we, mbe: be,
              maddr: AW'(da), mwd: wd, irv: irv, ird: ird, drv: drv, drd: drd};
        return v;
    endfunction

    function automatic vec_t idle_v(input logic irv, input logic [31:0] ird,
                                    input logic drv, input logic [31:0] drd);
        vec_t v;
        v = '{ir: 1'b0, ia: '0, dr: 1'b0, dwe: 1'b0, dbe: 4'h0, da: '0,
              dwd: 32'h0, ig: 1'b0, dg: 1'b0, men: 1'b0, mwe: 1'b0, mbe: 4'h0,
              maddr: '0, mwd: 32'h0, irv: irv, ird: ird, drv: drv, drd: drd};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, cur_row, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".if_gnt"},    32'(if_gnt),    32'h0);
        chk({tag, ".d_gnt"},     32'(d_gnt),     32'h0);
        chk({tag, ".mem_en"},    32'(mem_en),    32'h0);
        chk({tag, ".mem_we"},    32'(mem_we),    32'h0);
        chk({tag, ".mem_be"},    32'(mem_be),    32'h0);
        chk({tag, ".mem_addr"},  32'(mem_addr),  32'h0);
        chk({tag, ".mem_wdata"}, mem_wdata,      32'h0);
        chk({tag, ".if_rvalid"}, 32'(if_rvalid), 32'h0);
        chk({tag, ".d_rvalid"},  32'(d_rvalid),  32'h0);
        chk({tag, ".if_rdata"},  if_rdata,       32'h0);
        chk({tag, ".d_rdata"},   d_rdata,        32'h0);
    endtask

    task automatic drive(input vec_t v);
        if_req  = v.ir;
        if_addr = v.ia;
        d_req   = v.dr;
        d_we    = v.dwe;
        d_be    = v.dbe;
        d_addr  = v.da;
        d_wdata = v.dwd;
    endtask

    initial begin
        vec_t        v;
        logic [31:0] last_i;
        logic [31:0] last_d;
`ifdef RV32_ARB_STATS_EN
        logic [31:0] s_ig0, s_dg0, s_st0;
`endif
        last_i = 32'h0;
        last_d = 32'h0;

        // Fetch-only stream 0..7, returns start MEM_LAT cycles later.
        for (int k = 0; k < 8; k++)
            vecs.push_back(fetch_v(k, 1'b0, k >= 2, (k >= 2) ? a_word(k - 2) : 32'h0, 1'b0, 32'h0));
        // Simultaneous fetch and load from 0x10: data first, fetch next cycle.
        vecs.push_back(data_v(1'b1, 8, 1'b0, 4'hF, 16, 32'h0, 1'b1, a_word(6), 1'b0, 32'h0));
        vecs.push_back(fetch_v(8, 1'b0, 1'b1, a_word(7), 1'b0, 32'h0));
        vecs.push_back(idle_v(1'b0, 32'h0, 1'b1, 32'hDEADBEEF));
        // Partial store to 0x20 then load back.
        vecs.push_back(data_v(1'b0, 0, 1'b1, 4'b0011, 32, 32'h12345678, 1'b1, a_word(8), 1'b0, 32'h0));
        vecs.push_back(data_v(1'b0, 0, 1'b0, 4'hF, 32, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0));
        vecs.push_back(idle_v(1'b0, 32'h0, 1'b0, 32'h0));
        vecs.push_back(idle_v(1'b0, 32'h0, 1'b1, 32'hFFFF5678));
        // Continuous fetch and load traffic: D,D,D,D,I twice (rows 15..24).
        for (int k = 0; k < 4; k++)
            vecs.push_back(data_v(1'b1, 3, 1'b0, 4'hF, 16, 32'h0, 1'b0, 32'h0, k >= 2, (k >= 2) ? 32'hDEADBEEF : 32'h0));
        vecs.push_back(fetch_v(3, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF));
        vecs.push_back(data_v(1'b1, 4, 1'b0, 4'hF, 16, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF));
        vecs.push_back(data_v(1'b1, 4, 1'b0, 4'hF, 16, 32'h0, 1'b1, a_word(3), 1'b0, 32'h0));
        vecs.push_back(data_v(1'b1, 4, 1'b0, 4'hF, 16, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF));
        vecs.push_back(data_v(1'b1, 4, 1'b0, 4'hF, 16, 32'h0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF));
        vecs.push_back(fetch_v(4, 1'b1, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF));
        vecs.push_back(idle_v(1'b0, 32'h0, 1'b1, 32'hDEADBEEF));
        vecs.push_back(idle_v(1'b1, a_word(4), 1'b0, 32'h0));
        vecs.push_back(idle_v(1'b0, 32'h0, 1'b0, 32'h0));

        // Reset state, with both requests asserted to show grants stay low.
        if_req = 1'b1;
        d_req  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
`ifdef RV32_ARB_STATS_EN
        chk("reset.stat_if_gnt", stat_if_gnt, 32'h0);
        chk("reset.stat_d_gnt", stat_d_gnt, 32'h0);
        chk("reset.stat_if_stall", stat_if_stall, 32'h0);
`endif
        if_req = 1'b0;
        d_req  = 1'b0;
        rst_n  = 1'b1;

        for (int r = 0; r < vecs.size(); r++) begin
            v = vecs[r];
            @(posedge clk);
            #1;
`ifdef RV32_ARB_STATS_EN
            if (r == 15) begin
                s_ig0 = stat_if_gnt;
                s_dg0 = stat_d_gnt;
                s_st0 = stat_if_stall;
            end
            if (r == 25) begin
                cur_row = r;
                chk("stat_d_gnt_delta", stat_d_gnt - s_dg0, 32'd8);
                chk("stat_if_gnt_delta", stat_if_gnt - s_ig0, 32'd2);
                chk("stat_if_stall_delta", stat_if_stall - s_st0, 32'd8);
            end
`endif
            drive(v);
            @(negedge clk);
            cur_row = r;
            if (v.irv) last_i = v.ird;
            if (v.drv) last_d = v.drd;
            chk("if_gnt",    32'(if_gnt),    32'(v.ig));
            chk("d_gnt",     32'(d_gnt),     32'(v.dg));
            chk("mem_en",    32'(mem_en),    32'(v.men));
            chk("mem_we",    32'(mem_we),    32'(v.mwe));
            chk("mem_be",    32'(mem_be),    32'(v.mbe));
            chk("mem_addr",  32'(mem_addr),  32'(v.maddr));
            chk("mem_wdata", mem_wdata,      v.mwd);
            chk("if_rvalid", 32'(if_rvalid), 32'(v.irv));
            chk("d_rvalid",  32'(d_rvalid),  32'(v.drv));
            chk("if_rdata",  if_rdata,       last_i);
            chk("d_rdata",   d_rdata,        last_d);
        end

        // Reset one cycle after a read grant: everything quiet, no late rvalid.
        cur_row = 100;
        @(posedge clk);
        #1;
        if_req  = 1'b1;
        if_addr = AW'(5);
        d_req   = 1'b0;
        @(negedge clk);
        chk("rst_seq.if_gnt", 32'(if_gnt), 32'h1);
        @(posedge clk);
        #1;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_be   = 4'hF;
        d_addr = AW'(16);
        rst_n  = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        repeat (2) @(posedge clk);
        #1;
        if_req = 1'b0;
        d_req  = 1'b0;
        rst_n  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cur_row = 101 + c;
            @(negedge clk);
            chk("post_rst.if_rvalid", 32'(if_rvalid), 32'h0);
            chk("post_rst.d_rvalid",  32'(d_rvalid),  32'h0);
            @(posedge clk);
            #1;
        end

        // Recovery: a fresh fetch returns correct data after MEM_LAT.
        cur_row = 110;
        if_req  = 1'b1;
        if_addr = AW'(2);
        @(negedge clk);
        chk("recover.if_gnt", 32'(if_gnt), 32'h1);
        @(posedge clk);
        #1;
        if_req = 1'b0;
        @(negedge clk);
        chk("recover.if_rvalid_early", 32'(if_rvalid), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("recover.if_rvalid", 32'(if_rvalid), 32'h1);
        chk("recover.if_rdata", if_rdata, a_word(2));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rv32_mem_arbiter
